// File: rtl/freq_profile_seq_if.sv
// Host-side step-table write port of freq_profile_seq.
// The master modport is the register bank and the slave modport is the sequencer.
interface freq_profile_seq_if #(
  parameter int unsigned AW = 3
);
  logic          I_wr_en;
  logic [AW-1:0] I_wr_addr;
  logic [31:0]   I_wr_freq;
  logic [31:0]   I_wr_pha;
  logic [15:0]   I_wr_dwell;
  logic [15:0]   I_wr_pulses;
  logic          I_wr_limited;
  logic          O_wr_err;

  modport master (
    output I_wr_en, I_wr_addr, I_wr_freq, I_wr_pha,
    output I_wr_dwell, I_wr_pulses, I_wr_limited,
    input  O_wr_err
  );

  modport slave (
    input  I_wr_en, I_wr_addr, I_wr_freq, I_wr_pha,
    input  I_wr_dwell, I_wr_pulses, I_wr_limited,
    output O_wr_err
  );
endinterface

// File: rtl/freq_profile_seq.sv
// Speed-profile sequencer for one freq tachometer channel: steps through a table of speed steps.
// Optional FREQ_SEQ_TIMEOUT_EN: limited steps with nonzero dwell time out and advance.
module freq_profile_seq #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AW        = 3,
  parameter int unsigned LOAD_HOLD = 4,
  parameter int unsigned TICK_DIV  = 25000
) (
  input  logic                I_clk,
  input  logic                I_reset_n,
  freq_profile_seq_if.slave   wr,
  input  logic [AW-1:0]       I_last_idx,
  input  logic                I_loop,
  input  logic [31:0]         I_init_pulse,
  input  logic                I_start,
  input  logic                I_stop,
  input  logic                I_finished,
  output logic [31:0]         O_freq,
  output logic [31:0]         O_pha,
  output logic [15:0]         O_pluse_number,
  output logic                O_limited_Pluse,
  output logic [31:0]         O_init_pulse,
  output logic [1:0]          O_load,
  output logic                O_stat,
  output logic                O_busy,
  output logic                O_done,
  output logic                O_timeout,
  output logic [AW-1:0]       O_step_idx
);

  localparam int unsigned HW = $clog2(LOAD_HOLD + 1);
  localparam int unsigned TW = $clog2(TICK_DIV + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LOAD_HOLD - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_DWELL,
    S_NEXT,
    S_DONE
  } state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] tick_cnt;
  logic [15:0]   dwell_cnt;
  logic [15:0]   cur_dwell;
  logic          armed;
  logic          timeout_q;
  logic          wr_err_q;

  logic [31:0] t_freq   [DEPTH];
  logic [31:0] t_pha    [DEPTH];
  logic [15:0] t_dwell  [DEPTH];
  logic [15:0] t_pulses [DEPTH];
  logic        t_lim    [DEPTH];

  logic          at_last;
  logic          start_ok;
  logic          next_go;
  logic          ld_en;
  logic          dwell_hit;
  logic [AW-1:0] nxt_idx;
  logic [AW-1:0] ld_idx;

  assign wr.O_wr_err = wr_err_q;
  assign O_timeout   = timeout_q;

  // Table has no reset; writes only land while no sequence is running.
  always_ff @(posedge I_clk) begin
    if (wr.I_wr_en && !O_busy) begin
      t_freq[wr.I_wr_addr]   <= wr.I_wr_freq;
      t_pha[wr.I_wr_addr]    <= wr.I_wr_pha;
      t_dwell[wr.I_wr_addr]  <= wr.I_wr_dwell;
      t_pulses[wr.I_wr_addr] <= wr.I_wr_pulses;
      t_lim[wr.I_wr_addr]    <= wr.I_wr_limited;
    end
  end

  always_comb begin
    at_last   = (O_step_idx == I_last_idx);
    nxt_idx   = at_last ? '0 : O_step_idx + 1'b1;
    start_ok  = I_start && ((state == S_IDLE) || (state == S_DONE));
    next_go   = (state == S_NEXT) && (!at_last || I_loop);
    ld_en     = !I_stop && (start_ok || next_go);
    ld_idx    = (state == S_NEXT) ? nxt_idx : '0;
    dwell_hit = (cur_dwell != '0) && (tick_cnt == TICK_LAST) &&
                (dwell_cnt == cur_dwell - 16'd1);
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state           <= S_IDLE;
      hold_cnt        <= '0;
      tick_cnt        <= '0;
      dwell_cnt       <= '0;
      cur_dwell       <= '0;
      armed           <= 1'b0;
      timeout_q       <= 1'b0;
      wr_err_q        <= 1'b0;
      O_freq          <= '0;
      O_pha           <= '0;
      O_pluse_number  <= '0;
      O_limited_Pluse <= 1'b0;
      O_init_pulse    <= '0;
      O_load          <= '0;
      O_stat          <= 1'b0;
      O_busy          <= 1'b0;
      O_done          <= 1'b0;
      O_step_idx      <= '0;
    end else begin
      wr_err_q <= wr.I_wr_en && O_busy;
      if (I_stop) begin
        O_stat <= 1'b0;
        O_load <= '0;
        O_busy <= 1'b0;
        state  <= S_IDLE;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (I_start) begin
              O_step_idx   <= '0;
              O_stat       <= 1'b1;
              O_busy       <= 1'b1;
              O_done       <= 1'b0;
              timeout_q    <= 1'b0;
              O_init_pulse <= I_init_pulse;
              O_load       <= 2'b11;
              hold_cnt     <= '0;
              state        <= S_LOAD;
            end
          end
          S_LOAD: begin
            if (hold_cnt == HOLD_LAST) begin
              O_load   <= '0;
              hold_cnt <= '0;
              state    <= S_GAP;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          S_GAP: begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt  <= '0;
              tick_cnt  <= '0;
              dwell_cnt <= '0;
              armed     <= 1'b0;
              state     <= S_DWELL;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          S_DWELL: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (dwell_cnt != '1) dwell_cnt <= dwell_cnt + 16'd1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
            // A stale-high finished flag from the previous step must drop before it counts.
            if (!O_limited_Pluse) begin
              if (cur_dwell == '0 || dwell_hit) state <= S_NEXT;
            end else if (armed && I_finished) begin
              state <= S_NEXT;
`ifdef FREQ_SEQ_TIMEOUT_EN
            end else if (dwell_hit) begin
              timeout_q <= 1'b1;
              state     <= S_NEXT;
`endif
            end else if (!I_finished) begin
              armed <= 1'b1;
            end
          end
          S_NEXT: begin
            if (!at_last || I_loop) begin
              O_step_idx <= nxt_idx;
              O_load     <= 2'b01;
              hold_cnt   <= '0;
              state      <= S_LOAD;
            end else begin
              O_done <= 1'b1;
              O_busy <= 1'b0;
              state  <= S_DONE;
            end
          end
          default: state <= S_IDLE;
        endcase
        if (ld_en) begin
          O_freq          <= t_freq[ld_idx];
          O_pha           <= t_pha[ld_idx];
          O_pluse_number  <= t_pulses[ld_idx];
          O_limited_Pluse <= t_lim[ld_idx];
          cur_dwell       <= t_dwell[ld_idx];
        end
      end
    end
  end

endmodule
